muldiv_ctl: RTL
===============

// Module: muldiv_ctl
// PURPOSE
//  Iterative multiply/divide sequencer beside the execute stage. It owns the HI/LO registers,
//  runs MULT/MULTU (shift-add) and DIV/DIVU (restoring) over fixed 34 cycles, and raises a stall.
//  The stall holds MFHI/MFLO and back-to-back mul/div ops until the result is written.
//  Operands are the post-bypass a/bNoImm values from the EX stage; stall feeds the AnyStall OR.
// PARAMETERS
//  WIDTH   32  operand width; iteration count = WIDTH
//  CNT_W   5   iteration counter width, clog2(WIDTH)
// PORTS
//  clk          in   1      clock, all state on posedge
//  reset        in   1      synchronous, active-high; aborts any op
//  flush        in   1      kill current EX instr; blocks acceptance this cycle
//  ExtStall     in   1      stall from other sources (must NOT include MdStall_EX)
//  InstrVal_ID  in   1      EX-stage instruction valid
//  MdOp_ID      in   3      000 none,001 MULT,010 MULTU,011 DIV,100 DIVU,101 MTHI,110 MTLO
//  MdRd_ID      in   2      01 MFLO, 10 MFHI, 00/11 none
//  OpA_ID       in   WIDTH  rs operand (bypassed)
//  OpB_ID       in   WIDTH  rt operand (bypassed)
//  MdStall_EX   out  1      stall request to pipeline
//  MdBusy       out  1      state != IDLE
//  HiLoRd_EX    out  WIDTH  HI or LO per MdRd_ID; 0 when MdRd_ID none
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, HI=LO=0, MdBusy=0, MdStall_EX=0. Reset wins over all else.
//  Val = InstrVal_ID & ~flush & ~ExtStall. Start = Val & MdOp_ID in {001..100}.
//  FSM: IDLE -> MUL or DIV when Start and IDLE (edge E0).
//    At E0: latch |A|,|B| when signed else raw, with neg flags; cnt=0; acc cleared.
//  MUL/DIV: one iteration per edge E1..E32; cnt++; at cnt==WIDTH-1 the edge goes to FIXUP.
//  FIXUP: one cycle. At E33: sign-correct, write HI/LO, go to IDLE.
//  Busy for exactly 33 cycles after E0; result visible from the cycle after E33.
//  MULT/MULTU: {HI,LO} = 64-bit product; signed negates product when sa^sb.
//  DIV/DIVU: LO=quotient, HI=remainder. Signed: quotient neg if sa^sb, remainder takes sign of A.
//  Div by zero: fixed latency still; LO=32'hFFFF_FFFF, HI=OpA as latched at E0 (pre-abs).
//  0x80000000 / -1 (DIV): LO=0x80000000, HI=0. Falls out naturally; no special case.
//  MTHI/MTLO: when Val & IDLE, write HI/LO at next edge. Zero latency for a following MFHI/MFLO.
//  MdStall_EX = MdBusy & InstrVal_ID & (MdOp_ID!=000 | MdRd_ID in {01,10}). Combinational.
//  A stalled op is re-presented and accepted in the first IDLE cycle.
//  Start while busy is impossible (stalled). MTHI/MTLO while busy stall too.
//  flush mid-op: in-flight op completes and commits; flush only gates the current cycle's accept.
//  HiLoRd_EX is a combinational read of registered HI/LO. No bypass from an in-flight op.
//  Busy stall guarantees the registers are final.
//  Unused opcodes 111: treated as none.
// TESTING
//  MULT 7 x -3 -> after E33: HI=FFFFFFFF, LO=FFFFFFEB; MdBusy high exactly 33 cycles
//  MULTU FFFFFFFF x FFFFFFFF -> HI=FFFFFFFE, LO=00000001
//  DIV -7 / 2 -> LO=FFFFFFFD, HI=FFFFFFFF; DIVU 100/0 -> LO=FFFFFFFF, HI=00000064
//  MULT then MFLO next cycle -> MdStall_EX high 33 cycles; MFLO then returns new LO
//  DIV 80000000 / FFFFFFFF -> LO=80000000, HI=0; MTLO 5 when idle then MFLO -> 5
//  reset asserted at E10 of DIV -> IDLE, HI=LO=0, stall drops next cycle
//  flush on start cycle -> not accepted
//  ExtStall high 3 cycles with MULT presented -> accept only after ExtStall drops

Source files
------------

// File: rtl/muldiv_ctl.sv
// muldiv_ctl: iterative multiply/divide sequencer sitting beside the EX stage.
// Owns HI/LO. MULT/MULTU use a shift-add loop and DIV/DIVU a restoring loop.
// Every op takes a fixed 34 edges: accept, WIDTH iterations, one fix-up edge.
// The stall output holds HI/LO readers and further mul/div ops until the
// result has been committed. There is no bypass from an in-flight op.
module muldiv_ctl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             ExtStall,
  input  logic             InstrVal_ID,
  input  logic [2:0]       MdOp_ID,
  input  logic [1:0]       MdRd_ID,
  input  logic [WIDTH-1:0] OpA_ID,
  input  logic [WIDTH-1:0] OpB_ID,
  output logic             MdStall_EX,
  output logic             MdBusy,
  output logic [WIDTH-1:0] HiLoRd_EX
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DIV   = 2'd2,
    FIXUP = 2'd3
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t stateReg, stateNext;
  logic [CNT_W-1:0] cntReg;
  logic [WIDTH-1:0] hiReg, loReg;

  // Iteration datapath. For multiplies accLo holds the multiplier and accHi
  // the growing upper half; for divides accLo holds the dividend that turns
  // into the quotient, accHi the partial remainder. opBReg is the
  // multiplicand or divisor magnitude.
  logic [WIDTH-1:0] opBReg;
  logic [WIDTH-1:0] accHiReg, accLoReg;
  logic             isDivReg;
  logic             negResReg;   // product / quotient must be negated
  logic             negAReg;     // remainder must be negated (sign of A)
  logic             divZeroReg;  // divisor was zero at accept
  logic [WIDTH-1:0] rawAReg;     // dividend before taking magnitude

  // Acceptance decode
  logic             val;
  logic             start;
  logic             opIsMul;
  logic             opIsSigned;
  logic             idle;
  logic             opUsed;
  logic             rdUsed;
  logic [WIDTH-1:0] absA, absB;

  // Per-iteration arithmetic
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic [WIDTH:0]   divDiff;
  logic             divFits;

  // Fix-up arithmetic
  logic [2*WIDTH-1:0] prodRaw, prodFix;
  logic [WIDTH-1:0]   quoFix, remFix;

  // Decode the presented instruction and form operand magnitudes.
  always_comb begin
    idle       = (stateReg == IDLE);
    val        = InstrVal_ID & ~flush & ~ExtStall;
    start      = val & ((MdOp_ID == OP_MULT) | (MdOp_ID == OP_MULTU) |
                        (MdOp_ID == OP_DIV)  | (MdOp_ID == OP_DIVU));
    opIsMul    = (MdOp_ID == OP_MULT) | (MdOp_ID == OP_MULTU);
    opIsSigned = (MdOp_ID == OP_MULT) | (MdOp_ID == OP_DIV);
    // Opcode 111 is unused and behaves like "no op", including for stalls.
    opUsed     = (MdOp_ID != 3'b000) & (MdOp_ID != 3'b111);
    rdUsed     = (MdRd_ID == 2'b01) | (MdRd_ID == 2'b10);
    absA       = (opIsSigned & OpA_ID[WIDTH-1]) ? -OpA_ID : OpA_ID;
    absB       = (opIsSigned & OpB_ID[WIDTH-1]) ? -OpB_ID : OpB_ID;
  end

  // One shift-add step and one restoring-divide step, evaluated every cycle.
  always_comb begin
    mulSum   = {1'b0, accHiReg} + (accLoReg[0] ? {1'b0, opBReg} : '0);
    divShift = {accHiReg, accLoReg[WIDTH-1]};
    divDiff  = divShift - {1'b0, opBReg};
    // Partial remainder stays below the divisor, so a clear top bit means
    // the subtraction did not borrow.
    divFits  = ~divDiff[WIDTH];
  end

  // Sign correction applied on the fix-up edge.
  always_comb begin
    prodRaw = {accHiReg, accLoReg};
    prodFix = negResReg ? -prodRaw : prodRaw;
    quoFix  = negResReg ? -accLoReg : accLoReg;
    remFix  = negAReg ? -accHiReg : accHiReg;
  end

  // State register and iteration counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= IDLE;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      if (stateReg == IDLE) begin
        cntReg <= '0;
      end else if ((stateReg == MUL) || (stateReg == DIV)) begin
        cntReg <= (cntReg == LAST_ITER) ? '0 : cntReg + 1'b1;
      end
    end
  end

  // Next-state logic: accept from IDLE, iterate WIDTH times, fix up once.
  always_comb begin
    stateNext = stateReg;
    unique case (stateReg)
      IDLE: begin
        if (start) begin
          stateNext = opIsMul ? MUL : DIV;
        end
      end
      MUL, DIV: begin
        if (cntReg == LAST_ITER) begin
          stateNext = FIXUP;
        end
      end
      FIXUP: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Operand latch on accept, then one multiply or divide iteration per edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      opBReg     <= '0;
      accHiReg   <= '0;
      accLoReg   <= '0;
      isDivReg   <= 1'b0;
      negResReg  <= 1'b0;
      negAReg    <= 1'b0;
      divZeroReg <= 1'b0;
      rawAReg    <= '0;
    end else if (idle && start) begin
      opBReg     <= absB;
      accHiReg   <= '0;
      accLoReg   <= absA;
      isDivReg   <= ~opIsMul;
      negResReg  <= opIsSigned & (OpA_ID[WIDTH-1] ^ OpB_ID[WIDTH-1]);
      negAReg    <= opIsSigned & OpA_ID[WIDTH-1];
      divZeroReg <= (OpB_ID == '0);
      rawAReg    <= OpA_ID;
    end else if (stateReg == MUL) begin
      accHiReg <= mulSum[WIDTH:1];
      accLoReg <= {mulSum[0], accLoReg[WIDTH-1:1]};
    end else if (stateReg == DIV) begin
      accHiReg <= divFits ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
      accLoReg <= {accLoReg[WIDTH-2:0], divFits};
    end
  end

  // HI/LO: committed on the fix-up edge, or directly by MTHI/MTLO when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hiReg <= '0;
      loReg <= '0;
    end else if (stateReg == FIXUP) begin
      if (!isDivReg) begin
        hiReg <= prodFix[2*WIDTH-1:WIDTH];
        loReg <= prodFix[WIDTH-1:0];
      end else if (divZeroReg) begin
        hiReg <= rawAReg;
        loReg <= '1;
      end else begin
        hiReg <= remFix;
        loReg <= quoFix;
      end
    end else if (idle && val) begin
      if (MdOp_ID == OP_MTHI) begin
        hiReg <= OpA_ID;
      end else if (MdOp_ID == OP_MTLO) begin
        loReg <= OpA_ID;
      end
    end
  end

  // Busy, stall request and HI/LO read mux are purely combinational.
  always_comb begin
    MdBusy     = (stateReg != IDLE);
    MdStall_EX = MdBusy & InstrVal_ID & (opUsed | rdUsed);
    unique case (MdRd_ID)
      2'b01:   HiLoRd_EX = loReg;
      2'b10:   HiLoRd_EX = hiReg;
      default: HiLoRd_EX = '0;
    endcase
  end

endmodule
